// File: rtl/wb_sram32_pkg.sv
// Shared definitions for the Wishbone-to-async-SRAM bridge: FSM encoding,
// wait-counter width and the registered SRAM control bundle.
package wb_sram32_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_WR    = 3'd2,
      ST_WHOLD = 3'd3,
      ST_ACK   = 3'd4
   } state_e;

   typedef struct packed {
      logic [1:0] ce_n;
      logic [3:0] be_n;
      logic       oe_n;
      logic       we_n;
      logic       drv;
   } sram_ctl_t;

   localparam sram_ctl_t CTL_IDLE = '{ce_n: 2'b11, be_n: 4'hF, oe_n: 1'b1, we_n: 1'b1, drv: 1'b0};

   // Each 16-bit chip is enabled only if one of its two byte lanes is selected.
   function automatic logic [1:0] chip_ce_n(input logic [3:0] sel);
      return {~|sel[3:2], ~|sel[1:0]};
   endfunction

endpackage

// File: rtl/wb_sram32.sv
// Wishbone slave bridging to two 16-bit async SRAM chips forming a 32-bit word.
// Define WB_SRAM32_TURNAROUND_EN to add one dead IDLE cycle between a write and a following read.
module wb_sram32
   import wb_sram32_pkg::*;
#(
   parameter int adr_width = 18,
   parameter int latency   = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   input  logic                 wb_we_i,
   input  logic [31:0]          wb_adr_i,
   input  logic [3:0]           wb_sel_i,
   input  logic [31:0]          wb_dat_i,
   output logic [31:0]          wb_dat_o,
   output logic                 wb_ack_o,
   output logic [adr_width-1:0] sram_adr,
   output logic [3:0]           sram_be_n,
   output logic [1:0]           sram_ce_n,
   output logic                 sram_oe_n,
   output logic                 sram_we_n,
   inout  wire  [31:0]          sram_dat
);

   localparam logic [CNT_W-1:0] LAT = CNT_W'(latency);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [adr_width-1:0] adr_q, adr_d;
   logic [3:0]           sel_q, sel_d;
   logic [31:0]          wdat_q, wdat_d;
   logic [31:0]          rdat_q, rdat_d;
   logic                 ack_q, ack_d;
   logic                 abort_q, abort_d;
   sram_ctl_t            ctl_q, ctl_d;
   logic                 req, rd_block, end_abort;
   logic                 unused_adr;

   assign unused_adr = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

   // The ack cycle itself counts as the mandatory IDLE gap before the next request.
   assign req       = wb_cyc_i & wb_stb_i & ~ack_q;
   assign end_abort = abort_q | ~wb_cyc_i;

`ifdef WB_SRAM32_TURNAROUND_EN
   logic turn_q, turn_d;

   assign rd_block = turn_q & ~wb_we_i;

   // Armed by every write hold phase, consumed by the first IDLE cycle after the ack.
   always_comb begin
      turn_d = turn_q;
      if (state_q == ST_WHOLD)
         turn_d = 1'b1;
      else if (state_q == ST_IDLE && !ack_q)
         turn_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) turn_q <= 1'b0;
      else          turn_q <= turn_d;
   end
`else
   assign rd_block = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      sel_d   = sel_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      ack_d   = 1'b0;
      abort_d = abort_q;
      case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (req && !rd_block) begin
               adr_d   = wb_adr_i[adr_width+1:2];
               sel_d   = wb_sel_i;
               wdat_d  = wb_dat_i;
               cnt_d   = LAT;
               state_d = wb_we_i ? ST_WR : ST_RD;
            end
         end
         ST_RD: begin
            abort_d = end_abort;
            if (cnt_q == ONE) begin
               if (end_abort) begin
                  state_d = ST_IDLE;
               end else begin
                  rdat_d  = sram_dat;
                  state_d = ST_ACK;
               end
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         ST_WR: begin
            // A dropped cycle never shortens the we_n pulse; it only suppresses the ack.
            abort_d = end_abort;
            if (cnt_q == ONE) state_d = ST_WHOLD;
            else              cnt_d   = cnt_q - ONE;
         end
         ST_WHOLD: state_d = end_abort ? ST_IDLE : ST_ACK;
         ST_ACK: begin
            ack_d   = wb_cyc_i;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // SRAM strobes are registered from the next state so they switch cleanly with it.
   always_comb begin
      ctl_d = CTL_IDLE;
      if (state_d == ST_RD || state_d == ST_WR || state_d == ST_WHOLD) begin
         ctl_d.ce_n = chip_ce_n(sel_d);
         ctl_d.be_n = ~sel_d;
      end
      ctl_d.oe_n = (state_d != ST_RD);
      ctl_d.we_n = (state_d != ST_WR);
      ctl_d.drv  = (state_d == ST_WR) || (state_d == ST_WHOLD);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         sel_q   <= '0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         ack_q   <= 1'b0;
         abort_q <= 1'b0;
         ctl_q   <= CTL_IDLE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         ack_q   <= ack_d;
         abort_q <= abort_d;
         ctl_q   <= ctl_d;
      end
   end

   assign wb_dat_o  = rdat_q;
   assign wb_ack_o  = ack_q;
   assign sram_adr  = adr_q;
   assign sram_be_n = ctl_q.be_n;
   assign sram_ce_n = ctl_q.ce_n;
   assign sram_oe_n = ctl_q.oe_n;
   assign sram_we_n = ctl_q.we_n;
   assign sram_dat  = ctl_q.drv ? wdat_q : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_wb_sram32.sv
// Directed bench for wb_sram32: behavioural dual-chip SRAM on the default instance,
// plus a latency=4 instance fed by a constant-data SRAM stub.
module tb_wb_sram32;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cyc, stb, we;
   logic [31:0] adr, wdat;
   logic [3:0]  sel;
   logic [31:0] dat_o;
   logic        ack;
   logic [17:0] s_adr;
   logic [3:0]  s_be_n;
   logic [1:0]  s_ce_n;
   logic        s_oe_n, s_we_n;
   wire  [31:0] s_dat;

   logic        c4_cyc, c4_stb;
   logic [31:0] c4_dat_o;
   logic        c4_ack;
   logic [17:0] s4_adr;
   logic [3:0]  s4_be_n;
   logic [1:0]  s4_ce_n;
   logic        s4_oe_n, s4_we_n;
   wire  [31:0] s4_dat;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wb_sram32 dut (
      .clk(clk), .reset_n(reset_n),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat),
      .wb_dat_o(dat_o), .wb_ack_o(ack),
      .sram_adr(s_adr), .sram_be_n(s_be_n), .sram_ce_n(s_ce_n), .sram_oe_n(s_oe_n),
      .sram_we_n(s_we_n), .sram_dat(s_dat)
   );

   wb_sram32 #(.adr_width(18), .latency(4)) dut4 (
      .clk(clk), .reset_n(reset_n),
      .wb_cyc_i(c4_cyc), .wb_stb_i(c4_stb), .wb_we_i(1'b0), .wb_adr_i(32'h0000_0040),
      .wb_sel_i(4'hF), .wb_dat_i(32'h0),
      .wb_dat_o(c4_dat_o), .wb_ack_o(c4_ack),
      .sram_adr(s4_adr), .sram_be_n(s4_be_n), .sram_ce_n(s4_ce_n), .sram_oe_n(s4_oe_n),
      .sram_we_n(s4_we_n), .sram_dat(s4_dat)
   );

   // Behavioural SRAM: each chip drives its half when selected and output-enabled.
   logic [31:0] mem [0:255];
   assign s_dat[15:0]  = (!s_ce_n[0] && !s_oe_n) ? mem[s_adr[7:0]][15:0]  : 16'hzzzz;
   assign s_dat[31:16] = (!s_ce_n[1] && !s_oe_n) ? mem[s_adr[7:0]][31:16] : 16'hzzzz;
   assign s4_dat       = !s4_oe_n ? 32'hCAFE_F00D : 32'hzzzz_zzzz;

   always @(posedge clk) begin
      if (!s_we_n) begin
         if (!s_be_n[0] && !s_ce_n[0]) mem[s_adr[7:0]][7:0]   <= s_dat[7:0];
         if (!s_be_n[1] && !s_ce_n[0]) mem[s_adr[7:0]][15:8]  <= s_dat[15:8];
         if (!s_be_n[2] && !s_ce_n[1]) mem[s_adr[7:0]][23:16] <= s_dat[23:16];
         if (!s_be_n[3] && !s_ce_n[1]) mem[s_adr[7:0]][31:24] <= s_dat[31:24];
      end
   end

   task automatic bus_idle();
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   // Sample k is taken 1 ns after edge k; edge 0 is the request-sampling edge.
   task automatic do_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                           output int we_cnt, output int ack_k,
                           output logic [1:0] ce0, output logic [17:0] adr0);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = s; wdat = d;
      we_cnt = 0; ack_k = -1; ce0 = 2'bxx; adr0 = 'x;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin ce0 = s_ce_n; adr0 = s_adr; end
         if (!s_we_n) we_cnt++;
         if (ack) begin ack_k = k; break; end
      end
      bus_idle();
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int ack_k,
                          output int clash);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
      ack_k = -1; clash = 0; d = 'x;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (!s_oe_n && !s_we_n) clash++;
         if (ack) begin ack_k = k; d = dat_o; break; end
      end
      bus_idle();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus_idle(); adr = '0; sel = '0; wdat = '0;
      c4_cyc = 1'b0; c4_stb = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ack !== 1'b0)      begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
      checks++; if (dat_o !== 32'h0)   begin errors++; $display("FAIL reset_dat_o: got %h want 0", dat_o); end
      checks++; if (s_ce_n !== 2'b11)  begin errors++; $display("FAIL reset_ce_n: got %b want 11", s_ce_n); end
      checks++; if (s_oe_n !== 1'b1 || s_we_n !== 1'b1)
         begin errors++; $display("FAIL reset_oe_we: got oe=%b we=%b want 1 1", s_oe_n, s_we_n); end
      checks++; if (s_be_n !== 4'hF)   begin errors++; $display("FAIL reset_be_n: got %h want f", s_be_n); end
      checks++; if (s_adr !== 18'h0)   begin errors++; $display("FAIL reset_adr: got %h want 0", s_adr); end
      checks++; if (c4_ack !== 1'b0)   begin errors++; $display("FAIL reset_ack4: got %b want 0", c4_ack); end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      int wc, ak, cl; logic [1:0] ce0; logic [17:0] a0; logic [31:0] d;
      do_write(32'h0000_0010, 4'hF, 32'hDEAD_BEEF, wc, ak, ce0, a0);
      checks++; if (a0 !== 18'h004) begin errors++; $display("FAIL wr_adr: got %h want 004", a0); end
      checks++; if (wc != 2)        begin errors++; $display("FAIL wr_we_pulse: got %0d want 2", wc); end
      checks++; if (ak != 4)        begin errors++; $display("FAIL wr_latency: got %0d want 4", ak); end
      checks++; if (ce0 !== 2'b00)  begin errors++; $display("FAIL wr_ce_n: got %b want 00", ce0); end
      @(posedge clk); #1;
      do_read(32'h0000_0010, d, ak, cl);
      checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", d); end
      checks++; if (ak != 3)             begin errors++; $display("FAIL rd_latency: got %0d want 3", ak); end
      checks++; if (cl != 0)             begin errors++; $display("FAIL rd_oe_we_clash: got %0d want 0", cl); end
      @(posedge clk); #1;
      do_read(32'h0000_0013, d, ak, cl);
      checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_byte_bits: got %h want deadbeef", d); end
      @(posedge clk); #1;
   endtask

   task automatic test_byte_lanes();
      int wc, ak, cl; logic [1:0] ce0; logic [17:0] a0; logic [31:0] d;
      do_write(32'h0000_0080, 4'hF, 32'hAAAA_AAAA, wc, ak, ce0, a0);
      @(posedge clk); #1;
      do_write(32'h0000_0080, 4'b0011, 32'h1234_5678, wc, ak, ce0, a0);
      checks++; if (ce0 !== 2'b10) begin errors++; $display("FAIL lo_ce_n: got %b want 10", ce0); end
      @(posedge clk); #1;
      do_read(32'h0000_0080, d, ak, cl);
      checks++; if (d !== 32'hAAAA_5678) begin errors++; $display("FAIL lo_readback: got %h want aaaa5678", d); end
      @(posedge clk); #1;
      do_write(32'h0000_0080, 4'b0100, 32'h00CC_0000, wc, ak, ce0, a0);
      checks++; if (ce0 !== 2'b01) begin errors++; $display("FAIL b2_ce_n: got %b want 01", ce0); end
      @(posedge clk); #1;
      do_read(32'h0000_0080, d, ak, cl);
      checks++; if (d !== 32'hAACC_5678) begin errors++; $display("FAIL b2_readback: got %h want aacc5678", d); end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      int wc, acks, ak, cl; logic [1:0] ce3; logic [31:0] d;
      wc = 0; acks = 0; ce3 = 2'bxx;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_00C0; sel = 4'hF; wdat = 32'h0BAD_F00D;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (k == 0) bus_idle();
         if (!s_we_n) wc++;
         if (ack) acks++;
         if (k == 3) ce3 = s_ce_n;
      end
      checks++; if (wc != 2)       begin errors++; $display("FAIL abort_we_pulse: got %0d want 2", wc); end
      checks++; if (acks != 0)     begin errors++; $display("FAIL abort_ack: got %0d acks want 0", acks); end
      checks++; if (ce3 !== 2'b11) begin errors++; $display("FAIL abort_ce_release: got %b want 11", ce3); end
      do_read(32'h0000_00C0, d, ak, cl);
      checks++; if (d !== 32'h0BAD_F00D || ak != 3)
         begin errors++; $display("FAIL abort_followup: got %h lat %0d want 0badf00d lat 3", d, ak); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int wc, ak, cl; logic [1:0] ce0; logic [17:0] a0; logic [31:0] d;
      do_write(32'h0000_0100, 4'hF, 32'h5A5A_A5A5, wc, ak, ce0, a0);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0100; sel = 4'hF;
      @(posedge clk); #1;
      checks++; if (s_oe_n !== 1'b0) begin errors++; $display("FAIL rst_pre_oe: got %b want 0", s_oe_n); end
      reset_n = 1'b0;
      #1;
      checks++; if ({ack, s_ce_n, s_oe_n, s_we_n, s_be_n} !== {1'b0, 2'b11, 1'b1, 1'b1, 4'hF})
         begin errors++; $display("FAIL rst_mid_ctl: got ack=%b ce=%b oe=%b we=%b be=%h want 0 11 1 1 f",
                                  ack, s_ce_n, s_oe_n, s_we_n, s_be_n); end
      checks++; if (dat_o !== 32'h0 || s_adr !== 18'h0)
         begin errors++; $display("FAIL rst_mid_dat_adr: got dat=%h adr=%h want 0 0", dat_o, s_adr); end
      bus_idle();
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      do_read(32'h0000_0100, d, ak, cl);
      checks++; if (d !== 32'h5A5A_A5A5 || ak != 3)
         begin errors++; $display("FAIL rst_recover: got %h lat %0d want 5a5aa5a5 lat 3", d, ak); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int n_ce, n_ack, cl, gap; bit seen;
`ifdef WB_SRAM32_TURNAROUND_EN
      gap = 2;
`else
      gap = 1;
`endif
      seen = 0; n_ce = -1; n_ack = -1; cl = 0;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_0140; sel = 4'hF; wdat = 32'h1357_9BDF;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (ack) begin seen = 1; break; end
      end
      checks++; if (!seen) begin errors++; $display("FAIL b2b_write_ack: got none want ack"); end
      we = 1'b0;
      // n counts samples after the write-ack sample; sample 1 is the cycle after the ack cycle.
      for (int n = 1; n < 20; n++) begin
         @(posedge clk); #1;
         if (!s_oe_n && !s_we_n) cl++;
         if (n_ce < 0 && s_ce_n !== 2'b11) n_ce = n;
         if (ack) begin n_ack = n; break; end
      end
      checks++; if (n_ce - 1 != gap)
         begin errors++; $display("FAIL b2b_ce_gap: got %0d want %0d", n_ce - 1, gap); end
      checks++; if (n_ack != gap + 4)
         begin errors++; $display("FAIL b2b_read_ack: got %0d want %0d", n_ack, gap + 4); end
      checks++; if (dat_o !== 32'h1357_9BDF || cl != 0)
         begin errors++; $display("FAIL b2b_read_data: got %h clash %0d want 13579bdf clash 0", dat_o, cl); end
      bus_idle();
      @(posedge clk); #1;
   endtask

   task automatic test_latency4();
      int ak; logic [31:0] d;
      ak = -1; d = 'x;
      c4_cyc = 1'b1; c4_stb = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (c4_ack) begin ak = k; d = c4_dat_o; break; end
      end
      c4_cyc = 1'b0; c4_stb = 1'b0;
      checks++; if (ak != 5)             begin errors++; $display("FAIL lat4_ack: got %0d want 5", ak); end
      checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL lat4_data: got %h want cafef00d", d); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_latency4();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
